// File: rtl/led_pkg.sv
// Shared encodings and initial patterns for the LED pattern sequencer.
package led_pkg;

  localparam int unsigned LED_W  = 4;
  localparam int unsigned STEP_W = 8;

  typedef enum logic [1:0] {
    MODE_FLASH = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_PING  = 2'b10,
    MODE_BIN   = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [LED_W-1:0] PAT_FLASH_INIT = 4'b1111;
  localparam logic [LED_W-1:0] PAT_RUN_INIT   = 4'b0001;
  localparam logic [LED_W-1:0] PAT_PING_INIT  = 4'b0001;
  localparam logic [LED_W-1:0] PAT_BIN_INIT   = 4'b0001;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
    logic [LED_W-1:0] p;
    case (m)
      MODE_FLASH: p = PAT_FLASH_INIT;
      MODE_RUN:   p = PAT_RUN_INIT;
      MODE_PING:  p = PAT_PING_INIT;
      MODE_BIN:   p = PAT_BIN_INIT;
      default:    p = PAT_RUN_INIT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step timebase: counts 0..TICK_CYCLES-1 while enabled, pulses tick on the last count.
module led_tick_gen #(
  parameter int unsigned TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero whenever disabled so every run starts from a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: runs one of four patterns for STEPS steps, then goes dark and pulses done.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 5_000_000,
  parameter int unsigned STEPS       = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               dir_q, dir_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_c, clr_c;
  logic [LED_W-1:0]   pat_next_c;
  logic               dir_next_c;

  led_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .en   (state_q == ST_ACTIVE),
    .clr  (clr_c),
    .tick (tick_c)
  );

  // Next pattern for the latched mode; ping-pong bounces off either end.
  always_comb begin
    pat_next_c = led_q;
    dir_next_c = dir_q;
    case (mode_q)
      MODE_FLASH: pat_next_c = ~led_q;
      MODE_RUN:   pat_next_c = {led_q[2:0], led_q[3]};
      MODE_PING: begin
        if (dir_q == DIR_LEFT) begin
          if (led_q == 4'b1000) begin
            pat_next_c = led_q >> 1;
            dir_next_c = DIR_RIGHT;
          end else begin
            pat_next_c = led_q << 1;
          end
        end else begin
          if (led_q == 4'b0001) begin
            pat_next_c = led_q << 1;
            dir_next_c = DIR_LEFT;
          end else begin
            pat_next_c = led_q >> 1;
          end
        end
      end
      MODE_BIN:   pat_next_c = led_q + LED_W'(1);
      default:    pat_next_c = led_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    dir_d   = dir_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d  = '0;
        busy_d = 1'b0;
        step_d = '0;
        dir_d  = DIR_LEFT;
        if (start && !stop) begin
          state_d = ST_ACTIVE;
          mode_d  = mode_e'(mode);
          led_d   = init_pattern(mode_e'(mode));
          busy_d  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Abort outranks the tick, including the final one.
        if (stop) begin
          state_d = ST_IDLE;
          led_d   = '0;
          busy_d  = 1'b0;
          step_d  = '0;
          dir_d   = DIR_LEFT;
          clr_c   = 1'b1;
        end else if (tick_c) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_IDLE;
            led_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            step_d  = '0;
            dir_d   = DIR_LEFT;
            clr_c   = 1'b1;
          end else begin
            led_d  = pat_next_c;
            dir_d  = dir_next_c;
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FLASH;
      led_q   <= '0;
      dir_q   <= DIR_LEFT;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
